// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the 32-bit word and the memory responder state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } resp_state_t;

endpackage

// File: rtl/mem_responder.sv
// Memory responder: arbitrates datapath instruction/data requests onto one
// backing RAM port. Data beats instruction. A one-entry fetch buffer serves
// repeated fetches combinationally. Accesses that never see ram_ready abort
// after RAM_TIMEOUT cycles and set a sticky error flag.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int RAM_TIMEOUT = 31
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  ihit,
  output word_t imemload,
  output logic  dhit,
  output word_t dmemload,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load,
  input  logic  ram_ready,
  output logic  ram_err
);

  // The counter holds the number of access cycles already spent without
  // ram_ready; the abort fires in the cycle where it would reach RAM_TIMEOUT,
  // so a dead RAM costs exactly RAM_TIMEOUT access cycles.
  localparam logic [4:0] TMO_LAST = 5'(RAM_TIMEOUT - 1);

  resp_state_t state, nextState;

  word_t      latAddr;
  word_t      latStore;
  logic       latWrite;
  word_t      capData;
  logic [4:0] tmoCnt;

  logic       bufValid;
  word_t      bufAddr;
  word_t      bufData;

  logic       dReq;
  logic       bufHit;
  logic       inAcc;
  logic       tmoLast;

  assign dReq    = dmemREN | dmemWEN;
  assign bufHit  = bufValid && (bufAddr == imemaddr);
  assign inAcc   = (state == DACC) || (state == IACC);
  assign tmoLast = (tmoCnt == TMO_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: data first, then a fetch that misses the buffer.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (dReq)                      nextState = DACC;
        else if (imemREN && !bufHit)   nextState = IACC;
      end
      DACC: begin
        if (ram_ready)                 nextState = DRESP;
        else if (tmoLast)              nextState = IDLE;
      end
      IACC: begin
        if (ram_ready)                 nextState = IRESP;
        else if (tmoLast)              nextState = IDLE;
      end
      DRESP:                           nextState = IDLE;
      IRESP:                           nextState = IDLE;
      default:                         nextState = IDLE;
    endcase
  end

  // Latch the access on IDLE exit, then capture RAM data or count toward timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      latAddr  <= '0;
      latStore <= '0;
      latWrite <= 1'b0;
      capData  <= '0;
      tmoCnt   <= '0;
    end else if (state == IDLE) begin
      if (nextState != IDLE) begin
        latAddr  <= dReq ? dmemaddr : imemaddr;
        latStore <= dmemstore;
        latWrite <= dReq & dmemWEN;
        tmoCnt   <= '0;
      end
    end else if (inAcc) begin
      if (ram_ready)     capData <= ram_load;
      else if (!tmoLast) tmoCnt  <= tmoCnt + 5'd1;
    end
  end

  // Fetch buffer: filled on every IRESP, dropped by a colliding write or a timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bufValid <= 1'b0;
      bufAddr  <= '0;
      bufData  <= '0;
    end else begin
      if (state == IRESP) begin
        bufValid <= 1'b1;
        bufAddr  <= latAddr;
        bufData  <= capData;
      end else if (state == DRESP && latWrite && latAddr == bufAddr) begin
        bufValid <= 1'b0;
      end else if (inAcc && !ram_ready && tmoLast) begin
        bufValid <= 1'b0;
      end
    end
  end

  // Sticky timeout flag; cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)                                ram_err <= 1'b0;
    else if (inAcc && !ram_ready && tmoLast) ram_err <= 1'b1;
  end

  // Hit/load outputs. A request dropped before its RESP cycle gets no hit.
  // Buffer hits are only served when no data request is competing, which
  // also keeps ihit and dhit mutually exclusive.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    dhit     = 1'b0;
    dmemload = '0;
    unique case (state)
      IDLE: begin
        if (!dReq && imemREN && bufHit) begin
          ihit     = 1'b1;
          imemload = bufData;
        end
      end
      DRESP: begin
        if (dReq) begin
          dhit     = 1'b1;
          dmemload = capData;
        end
      end
      IRESP: begin
        if (imemREN) begin
          ihit     = 1'b1;
          imemload = capData;
        end
      end
      default: ;
    endcase
  end

  // RAM strobes are decoded from state; address/data come straight from the latches.
  always_comb begin
    ram_ren   = (state == IACC) || ((state == DACC) && !latWrite);
    ram_wen   = (state == DACC) && latWrite;
    ram_addr  = latAddr;
    ram_store = latStore;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: fetch/buffer, arbitration, invalidate,
// timeout, reset-mid-access and withdrawal scenarios.
module tb_mem_responder;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  imemREN = 1'b0;
  word_t imemaddr = '0;
  logic  dmemREN = 1'b0;
  logic  dmemWEN = 1'b0;
  word_t dmemaddr = '0;
  word_t dmemstore = '0;
  logic  ihit, dhit, ram_ren, ram_wen, ram_err;
  word_t imemload, dmemload, ram_addr, ram_store;
  word_t ram_load = '0;
  logic  ram_ready = 1'b0;

  int nCmp = 0;
  int nErr = 0;

  mem_responder #(.RAM_TIMEOUT(31)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK)
    if (!RST) chk("ihit_dhit_excl", 32'(ihit & dhit), 0);

  logic okRen, sawHit;

  initial begin
    // reset
    tick(); tick();
    RST = 1'b0; #1;
    chk("rst_ihit", 32'(ihit), 0);
    chk("rst_dhit", 32'(dhit), 0);
    chk("rst_ren", 32'(ram_ren), 0);
    chk("rst_wen", 32'(ram_wen), 0);
    chk("rst_err", 32'(ram_err), 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_dmemload", dmemload, 0);

    // fetch 0x40, ready on 3rd IACC cycle
    imemREN = 1'b1; imemaddr = 32'h40; #1;
    chk("fetch_miss", 32'(ihit), 0);
    tick(); #1;
    chk("fetch_ren", 32'(ram_ren), 1);
    chk("fetch_addr", ram_addr, 32'h40);
    tick();
    tick(); ram_ready = 1'b1; ram_load = 32'h8C220004; #1;
    chk("fetch_nohit_acc", 32'(ihit), 0);
    tick(); ram_ready = 1'b0; #1;
    chk("fetch_ihit", 32'(ihit), 1);
    chk("fetch_load", imemload, 32'h8C220004);
    chk("fetch_resp_ren", 32'(ram_ren), 0);
    tick(); #1;
    chk("bufhit_ihit", 32'(ihit), 1);
    chk("bufhit_load", imemload, 32'h8C220004);
    chk("bufhit_ren", 32'(ram_ren), 0);
    tick(); #1;
    chk("bufhit_stay_ren", 32'(ram_ren), 0);
    imemREN = 1'b0;

    // arbitration: data first, then fetch of 0x80
    imemREN = 1'b1; imemaddr = 32'h80; dmemREN = 1'b1; dmemaddr = 32'h100; #1;
    chk("arb_idle_ihit", 32'(ihit), 0);
    tick(); #1;
    chk("arb_addr_d", ram_addr, 32'h100);
    chk("arb_ren_d", 32'(ram_ren), 1);
    chk("arb_wen_d", 32'(ram_wen), 0);
    ram_ready = 1'b1; ram_load = 32'h11112222;
    tick(); ram_ready = 1'b0; #1;
    chk("arb_dhit", 32'(dhit), 1);
    chk("arb_dload", dmemload, 32'h11112222);
    chk("arb_ihit_d", 32'(ihit), 0);
    dmemREN = 1'b0;
    tick(); #1;
    chk("arb_idle2_ihit", 32'(ihit), 0);
    tick(); #1;
    chk("arb_addr_i", ram_addr, 32'h80);
    chk("arb_ren_i", 32'(ram_ren), 1);
    ram_ready = 1'b1; ram_load = 32'h22223333;
    tick(); ram_ready = 1'b0; #1;
    chk("arb_ihit", 32'(ihit), 1);
    chk("arb_iload", imemload, 32'h22223333);
    imemREN = 1'b0;
    tick();

    // invalidate: buffer 0x40, write 0x40, refetch must go to RAM
    imemREN = 1'b1; imemaddr = 32'h40; #1;
    chk("inv_pre_miss", 32'(ihit), 0);
    tick(); ram_ready = 1'b1; ram_load = 32'hAAAA0001;
    tick(); ram_ready = 1'b0; #1;
    chk("inv_fill_ihit", 32'(ihit), 1);
    tick(); #1;
    chk("inv_buffered", 32'(ihit), 1);
    chk("inv_buf_load", imemload, 32'hAAAA0001);
    imemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hDEADBEEF;
    tick(); #1;
    chk("inv_wen", 32'(ram_wen), 1);
    chk("inv_ren", 32'(ram_ren), 0);
    chk("inv_addr", ram_addr, 32'h40);
    chk("inv_store", ram_store, 32'hDEADBEEF);
    ram_ready = 1'b1; ram_load = '0;
    tick(); ram_ready = 1'b0; #1;
    chk("inv_dhit", 32'(dhit), 1);
    dmemWEN = 1'b0;
    tick(); imemREN = 1'b1; imemaddr = 32'h40; #1;
    chk("inv_refetch_miss", 32'(ihit), 0);
    tick(); #1;
    chk("inv_refetch_ren", 32'(ram_ren), 1);
    chk("inv_refetch_addr", ram_addr, 32'h40);
    ram_ready = 1'b1; ram_load = 32'hDEADBEEF;
    tick(); ram_ready = 1'b0; #1;
    chk("inv_refetch_ihit", 32'(ihit), 1);
    chk("inv_refetch_load", imemload, 32'hDEADBEEF);
    imemREN = 1'b0;
    tick();

    // timeout: ram_ready never arrives for 31 access cycles
    dmemREN = 1'b1; dmemaddr = 32'h200; #1;
    chk("tmo_err_before", 32'(ram_err), 0);
    okRen = 1'b1; sawHit = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick(); #1;
      if (!ram_ren) okRen = 1'b0;
      if (dhit || ihit) sawHit = 1'b1;
    end
    chk("tmo_ren_held", 32'(okRen), 1);
    chk("tmo_no_hit", 32'(sawHit), 0);
    tick(); #1;
    chk("tmo_abort_ren", 32'(ram_ren), 0);
    chk("tmo_err", 32'(ram_err), 1);
    chk("tmo_dhit", 32'(dhit), 0);
    dmemREN = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; #1;
    chk("tmo_buf_cleared", 32'(ihit), 0);

    // refill buffer, then reset in DACC cycle 2
    tick(); ram_ready = 1'b1; ram_load = 32'h12345678;
    tick(); ram_ready = 1'b0; #1;
    chk("rst_fill_ihit", 32'(ihit), 1);
    imemREN = 1'b0;
    tick(); imemREN = 1'b1; #1;
    chk("rst_pre_buffered", 32'(ihit), 1);
    chk("err_sticky", 32'(ram_err), 1);
    imemREN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h300;
    tick();
    tick(); #1;
    chk("rst_dacc2_ren", 32'(ram_ren), 1);
    RST = 1'b1;
    tick(); RST = 1'b0; dmemREN = 1'b0; #1;
    chk("rstmid_ren", 32'(ram_ren), 0);
    chk("rstmid_dhit", 32'(dhit), 0);
    chk("rstmid_err", 32'(ram_err), 0);
    imemREN = 1'b1; imemaddr = 32'h40; #1;
    chk("rstmid_buf_cleared", 32'(ihit), 0);
    imemREN = 1'b0;
    tick();

    // withdrawal: dmemREN dropped before ram_ready
    dmemREN = 1'b1; dmemaddr = 32'h400;
    tick(); dmemREN = 1'b0; #1;
    chk("wd_ren1", 32'(ram_ren), 1);
    tick(); #1;
    chk("wd_ren2", 32'(ram_ren), 1);
    chk("wd_addr", ram_addr, 32'h400);
    ram_ready = 1'b1; ram_load = 32'h55555555;
    tick(); ram_ready = 1'b0; #1;
    chk("wd_no_dhit", 32'(dhit), 0);
    tick(); #1;
    chk("wd_idle_ren", 32'(ram_ren), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter RAM_TIMEOUT, default 31, meaning cycles to wait for ram_ready before aborting an access.
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port imemREN  input  1  instruction read request from the datapath.
REQ-005 The block SHALL have port imemaddr  input  32  instruction word address.
REQ-006 The block SHALL have port dmemREN  input  1  data read request.
REQ-007 The block SHALL have port dmemWEN  input  1  data write request.
REQ-008 The block SHALL have port dmemaddr  input  32  data word address.
REQ-009 The block SHALL have port dmemstore  input  32  data to write.
REQ-010 The block SHALL have port ihit  output  1  instruction access complete; imemload valid.
REQ-011 The block SHALL have port imemload  output  32  fetched instruction.
REQ-012 The block SHALL have port dhit  output  1  data access complete; dmemload valid on reads.
REQ-013 The block SHALL have port dmemload  output  32  loaded data.
REQ-014 The block SHALL have ports ram_ren, ram_wen  output  1 each  backing RAM read/write strobes.
REQ-015 The block SHALL have ports ram_addr and ram_store  output  32 each  RAM address and write data.
REQ-016 The block SHALL have port ram_load  input  32  RAM read data, valid while ram_ready is high.
REQ-017 The block SHALL have port ram_ready  input  1  one-cycle RAM completion pulse.
REQ-018 The block SHALL have port ram_err  output  1  sticky RAM-timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, DACC, IACC, DRESP, IRESP.
REQ-020 In IDLE, a data request (dmemREN or dmemWEN) SHALL move the FSM to DACC; otherwise imemREN with a buffer miss SHALL move it to IACC; data SHALL always win over instruction.
REQ-021 The address, write data and request type SHALL be latched on the IDLE exit edge and held stable on ram_* for the whole access.
REQ-022 In DACC/IACC, ram_ren or ram_wen SHALL stay asserted until ram_ready, then the FSM SHALL move to DRESP/IRESP with ram_load captured.
REQ-023 In DRESP/IRESP, dhit/ihit SHALL be high for exactly one cycle with the captured data, then the FSM SHALL return to IDLE.
REQ-024 Minimum data latency SHALL be request-to-dhit = 2 cycles when ram_ready arrives in the first DACC cycle.
REQ-025 A one-entry fetch buffer (valid, addr, data) SHALL be loaded on every IRESP.
REQ-026 In IDLE, with no data request, imemREN and a valid buffer entry whose addr equals imemaddr SHALL assert ihit combinationally that cycle with the buffered data, and SHALL NOT start a RAM access.
REQ-027 A data write whose latched address equals the buffer addr SHALL clear buffer valid on DRESP.
REQ-028 A request withdrawn mid-access SHALL still complete the RAM transaction, and its hit SHALL be suppressed if the request is no longer asserted in the RESP cycle.
REQ-029 A 5-bit counter SHALL count cycles in DACC/IACC.
REQ-030 When that counter reaches RAM_TIMEOUT without ram_ready, the access SHALL abort to IDLE with no hit, ram_err SHALL set, and buffer valid SHALL clear.
REQ-031 ihit and dhit SHALL never be high in the same cycle.
REQ-032 All addresses SHALL be used unmodified (word-aligned by the datapath); no arithmetic SHALL be applied.

Reset
REQ-033 While RST is high at a rising edge: FSM to IDLE, buffer valid 0, counter 0, ram_err 0.
REQ-034 All outputs SHALL be 0 in the cycle after reset.
REQ-035 Reset mid-access SHALL drop ram_ren and ram_wen on the next edge without producing a hit.

Structure
REQ-036 The state enum resp_state_t SHALL be placed in cpu_types_pkg; word_t SHALL be reused for all 32-bit fields.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 Fetch scenario: imemREN=1, imemaddr=0x40, ram_ready on the 3rd IACC cycle with ram_load=0x8C220004 -> ihit pulses once with imemload=0x8C220004; repeating imemaddr=0x40 gives an immediate ihit with no ram_ren.
REQ-039 Arbitration scenario: imemREN and dmemREN asserted together, dmemaddr=0x100 -> ram_addr=0x100 first, dhit, then the instruction fetch proceeds.
REQ-040 Buffer-invalidate scenario: buffered fetch at 0x40, then dmemWEN to 0x40 with dmemstore=0xDEADBEEF -> the next fetch of 0x40 re-reads RAM.
REQ-041 Timeout scenario: ram_ready held low for 31 cycles -> FSM returns to IDLE, ram_err=1, no hit.
REQ-042 Reset scenario: RST asserted in DACC cycle 2 -> next cycle ram_ren=0, dhit=0, and buffer valid is cleared.
REQ-043 Withdrawal scenario: dmemREN dropped before ram_ready -> RAM access completes and dhit stays 0.
